// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit_pkg
//  Brief    : Shared types and constants for the instruction fetch front-end
//  Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_unit_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam int          INSTR_W = 32;
    localparam int          PC_INC  = 4;
    localparam logic [31:0] NOP     = 32'h0;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Brief    : Prefetch FIFO holding {pc, instr} pairs; flush beats push/pop
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter  int ADDR_W = 32,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    output logic [CNT_W-1:0]   count,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Storage, pointers and occupancy; storage is cleared on reset so the
    // head outputs read as zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= NOP;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit
//  Brief    : Fetch PC owner, imem req/ack sequencer and prefetch buffer
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] fpc, fpc_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [ADDR_W-1:0] fpc_inc;
    logic [ADDR_W-1:0] redirect_target;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_after;
    logic              push;
    logic              pop;
    logic              flush;

    // Redirect targets are word aligned; the low two bits are dropped.
    assign redirect_target = redirect_pc & ~ADDR_W'(3);
    assign fpc_inc         = fpc + ADDR_W'(PC_INC);
    assign pop             = out_valid && out_ready;
    // Occupancy after a push in REQ combined with any pop this cycle.
    assign count_after     = count + CNT_W'(1) - CNT_W'(pop);
    assign imem_req        = (state == REQ) || (state == DROP);
    assign out_valid       = (count != '0);

    // State, fetch PC and request address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fpc       <= RESET_PC;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_nx;
            fpc       <= fpc_nx;
            imem_addr <= addr_nx;
        end
    end

    // Next-state, PC update and FIFO control; redirect always wins
    always_comb begin
        state_nx = state;
        fpc_nx   = fpc;
        addr_nx  = imem_addr;
        push     = 1'b0;
        flush    = 1'b0;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fpc_nx = redirect_target;
                    flush  = 1'b1;
                end else if (count < CNT_W'(DEPTH)) begin
                    state_nx = REQ;
                    addr_nx  = fpc;
                end
            end
            REQ: begin
                if (redirect) begin
                    // Acked data is stale; an unacked request must still
                    // complete, so it is drained in DROP.
                    fpc_nx   = redirect_target;
                    flush    = 1'b1;
                    state_nx = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    push   = 1'b1;
                    fpc_nx = fpc_inc;
                    if (count_after < CNT_W'(DEPTH)) begin
                        addr_nx = fpc_inc;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    fpc_nx = redirect_target;
                    flush  = 1'b1;
                end
                if (imem_ack) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_pc    (fpc),
        .push_instr (imem_rdata),
        .count      (count),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );

endmodule
`default_nettype wire

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch front-end sitting directly upstream of the single-cycle datapath.
- Owns the fetch PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small prefetch FIFO and hands them to the datapath over valid/ready.
- Accepts branch/jump redirects from the datapath, flushing stale and in-flight fetches.

Parameters:
ADDR_W, 32, width of PC and memory address
RESET_PC, 32'h0, fetch address after reset
DEPTH, 2, prefetch FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request, held until ack
imem_addr  out  ADDR_W  word address of request, stable while imem_req=1
imem_ack  in  1  memory accepts request; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
redirect  in  1  taken branch/jump from datapath
redirect_pc  in  ADDR_W  new fetch target
out_valid  out  1  FIFO head valid
out_instr  out  32  head instruction
out_pc  out  ADDR_W  PC of head instruction
out_ready  in  1  datapath consumes head this cycle

Behaviour:
- Reset (rst=1 at an edge, any state, mid-request included) sets:
  - state=IDLE, fpc=RESET_PC, count=0, pointers=0.
  - imem_req=0, imem_addr=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0.
  - A pending ack is ignored.
- Handshake rules:
  - Transfer occurs on imem_req&&imem_ack. At most one outstanding request.
  - imem_addr changes only on an IDLE->REQ entry or on a REQ->REQ back-to-back transfer.
- FSM IDLE:
  - redirect=1: fpc<=redirect_pc with bits[1:0] forced 0; FIFO flushed; stay IDLE.
  - Otherwise, if count<DEPTH: ->REQ, imem_addr<=fpc, imem_req<=1.
- FSM REQ:
  - ack&&!redirect: push {fpc,imem_rdata}; fpc<=fpc+4, wrapping mod 2^ADDR_W.
    - If count after push and pop <DEPTH: stay REQ with imem_addr<=fpc+4.
    - Else ->IDLE with imem_req<=0.
  - redirect&&ack: data discarded, no push; fpc<=redirect_pc; flush; ->IDLE.
  - redirect&&!ack: fpc<=redirect_pc; flush; ->DROP. imem_req and imem_addr held.
- FSM DROP:
  - imem_req held at the old address until ack; data discarded on ack; ->IDLE.
  - A further redirect in DROP overwrites fpc and flushes again; stays DROP unless ack.
- FIFO:
  - out_valid=(count!=0); out_instr/out_pc come from registered head storage.
  - Pop on out_valid&&out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - No push when count==DEPTH; the FSM guarantees this.
- Redirect priority: redirect beats pop and push in the same cycle. Count goes to 0 and out_valid=0 the next cycle.
- Latency: with ack asserted the same cycle as req, the first instruction after reset/redirect appears 2 cycles after entering IDLE. Steady-state throughput is 1 instr/cycle when out_ready=1 and ack=1.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, DROP=2'd2).
  - INSTR_W=32, PC_INC=4.
  - NOP=32'h0.
- One sub-module, fetch_fifo: parametric DEPTH, {pc,instr} payload, push/pop/flush, count, head outputs, synchronous reset.

Test Plan:
- Reset then ack tied 1, out_ready=1 -> imem_addr sequence 0,4,8,...; out_pc 0,4,8 one per cycle; out_instr matches memory model.
- out_ready=0 with ack=1 -> after 2 pushes count=2, imem_req drops to 0, out_pc held at 0; out_ready=1 resumes fetch at 8.
- Memory ack delayed 3 cycles, redirect to 0x100 in cycle 1 of wait -> DROP, old addr held until ack, no push, next req addr=0x100, first out_pc=0x100.
- Redirect same cycle as ack and out_ready=1 with FIFO non-empty -> no push, FIFO flushed, out_valid=0 next cycle, next imem_addr=redirect_pc.
- Redirect to 0x203 -> fetch at 0x200; fpc at 0xFFFFFFFC followed by ack -> next fpc 0x0.
- rst asserted in REQ with ack high -> no push, all outputs return to reset values next cycle, first req addr=RESET_PC.
